// File: rtl/ifid_decode_queue.sv
// ifid_decode_queue: DEPTH-entry fetch-to-decode FIFO that stores six control flags decoded at push time.
// Define IFID_BYPASS_EN so a push into an empty queue is presented at the head in the same cycle.
module ifid_decode_queue #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [63:0]   push_data,
   output logic          pop_valid,
   input  logic          pop_ready,
   output logic [63:0]   pop_data,
   output logic          ExtOp,
   output logic          ImmCh,
   output logic          ShamtCh,
   output logic          ShiftCtr,
   output logic          Jump,
   output logic          JumpReg,
   output logic [AW:0]   count
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [63:0]   mem [DEPTH];
   logic [5:0]    flg [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          q_valid, byp, wr_en, rd_en;
   logic [63:0]   head_data;
   logic [5:0]    head_flg;

   function automatic logic [5:0] decode(input logic [31:0] i);
      logic [5:0] op, fn;
      logic       ext;
      op  = i[31:26];
      fn  = i[5:0];
      ext = op inside {6'h08, 6'h09, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0A,
                       6'h0B, 6'h01, 6'h07, 6'h06, 6'h20, 6'h24, 6'h28};
      return {ext,
              ext || (op inside {[6'h0C:6'h0F]}),
              op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03}),
              op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}),
              op inside {6'h02, 6'h03},
              op == 6'h00 && (fn inside {6'h08, 6'h09})};
   endfunction

   assign push_ready = count < FULL;
   assign q_valid    = count != '0 && !flush;
`ifdef IFID_BYPASS_EN
   assign byp       = count == '0 && push_valid && !flush;
   assign head_data = byp ? push_data : mem[rd_ptr];
   assign head_flg  = byp ? decode(push_data[31:0]) : flg[rd_ptr];
`else
   assign byp       = 1'b0;
   assign head_data = mem[rd_ptr];
   assign head_flg  = flg[rd_ptr];
`endif
   assign pop_valid = q_valid || byp;
   assign rd_en     = q_valid && pop_ready;
   // A bypassed word taken by decode in the same cycle never enters storage.
   assign wr_en     = push_valid && push_ready && !flush && !(byp && pop_ready);
   assign pop_data  = pop_valid ? head_data : '0;
   assign {ExtOp, ImmCh, ShamtCh, ShiftCtr, Jump, JumpReg} = pop_valid ? head_flg : '0;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_en);
         rd_ptr <= rd_ptr + AW'(rd_en);
         count  <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end

   always_ff @(posedge clk)
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
         flg[wr_ptr] <= decode(push_data[31:0]);
      end
endmodule

// File: tb/tb_ifid_decode_queue.sv
// tb_ifid_decode_queue: vector table, hand sequences and random traffic against a queue-based reference.
// Honours IFID_BYPASS_EN to match the design build.
module tb_ifid_decode_queue;
   localparam int D = 4;
   logic        clk = 0, rst = 1, flush = 0, push_valid = 0, pop_ready = 0;
   logic [63:0] push_data = '0;
   logic        push_ready, pop_valid;
   logic [63:0] pop_data;
   logic        ExtOp, ImmCh, ShamtCh, ShiftCtr, Jump, JumpReg;
   logic [2:0]  count;
   logic [5:0]  flags;
   int          checks = 0, errors = 0;
   logic [63:0] q[$];
   logic        s_valid, s_pr;
   logic [63:0] s_data;
   logic [5:0]  s_flags;
   logic [2:0]  s_count;

   typedef struct {
      logic fl, pv; logic [63:0] pd; logic pr;
      logic ev; logic [63:0] ed; logic [5:0] ef; int ec; logic epr;
   } vec_t;
   vec_t tv[$];

   localparam logic [63:0] LW  = 64'h00000004_8C410008;
   localparam logic [63:0] JR  = 64'h00000010_03E00008;
   localparam logic [63:0] JJ  = 64'h00000014_08000010;
   localparam logic [63:0] ORI = 64'h00000018_34210001;
   localparam logic [63:0] ADI = 64'h0000001C_20010005;

   ifid_decode_queue #(.DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid), .push_ready(push_ready),
      .push_data(push_data), .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
      .ExtOp(ExtOp), .ImmCh(ImmCh), .ShamtCh(ShamtCh), .ShiftCtr(ShiftCtr), .Jump(Jump),
      .JumpReg(JumpReg), .count(count));

   assign flags = {ExtOp, ImmCh, ShamtCh, ShiftCtr, Jump, JumpReg};
   always #5 clk = ~clk;

   function automatic logic [5:0] ref_flags(input logic [31:0] i);
      int ext_ops[14] = '{'h08, 'h09, 'h04, 'h05, 'h23, 'h2B, 'h0A, 'h0B, 'h01, 'h07, 'h06, 'h20, 'h24, 'h28};
      int op = int'(i[31:26]), fn = int'(i[5:0]);
      bit e = 0;
      foreach (ext_ops[k]) if (ext_ops[k] == op) e = 1;
      return {e, e || (op >= 'h0C && op <= 'h0F),
              op == 0 && (fn == 0 || fn == 2 || fn == 3),
              op == 0 && (fn <= 7 && fn != 1 && fn != 5),
              op == 2 || op == 3,
              op == 0 && (fn == 8 || fn == 9)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic fl, input logic pv, input logic [63:0] pd, input logic pr);
      int n;
      bit b, ev;
      logic [63:0] ed;
      flush = fl; push_valid = pv; push_data = pd; pop_ready = pr;
      #2;
      n = q.size();
`ifdef IFID_BYPASS_EN
      b = n == 0 && pv && !fl;
`else
      b = 0;
`endif
      ev = (n != 0 && !fl) || b;
      ed = '0;
      if (b) ed = pd;
      else if (ev) ed = q[0];
      chk("pop_valid", 64'(pop_valid), 64'(ev));
      chk("pop_data", pop_data, ed);
      chk("flags", 64'(flags), ev ? 64'(ref_flags(ed[31:0])) : 64'd0);
      chk("count", 64'(count), 64'(n));
      chk("push_ready", 64'(push_ready), 64'(n < D));
      s_valid = pop_valid; s_data = pop_data; s_flags = flags; s_count = count; s_pr = push_ready;
      @(posedge clk);
      if (fl) q.delete();
      else if (!(b && pr)) begin
         if (ev && pr) void'(q.pop_front());
         if (pv && n < D) q.push_back(pd);
      end
      #1;
   endtask

   task automatic add(input logic fl, input logic pv, input logic [63:0] pd, input logic pr,
                      input logic ev, input logic [63:0] ed, input logic [5:0] ef, input int ec, input logic epr);
      tv.push_back('{fl, pv, pd, pr, ev, ed, ef, ec, epr});
   endtask

   function automatic logic [63:0] w(input int n);
      return {32'(n), 32'(n)};
   endfunction

   function automatic logic [63:0] cv(input int n);
      return {32'hA000_0000 + 32'(n), 32'h2000_0000 + 32'(n)};
   endfunction

   initial begin
      add(0, 0, 0,    0, 0, 0,    6'b000000, 0, 1);
      add(0, 1, LW,   0, 0, 0,    6'b000000, 0, 1);
      add(0, 0, 0,    0, 1, LW,   6'b110000, 1, 1);
      add(0, 0, 0,    1, 1, LW,   6'b110000, 1, 1);
      add(0, 1, w(0), 0, 0, 0,    6'b000000, 0, 1);
      add(0, 1, w(1), 0, 1, w(0), 6'b001100, 1, 1);
      add(0, 1, w(2), 0, 1, w(0), 6'b001100, 2, 1);
      add(0, 1, w(3), 0, 1, w(0), 6'b001100, 3, 1);
      add(0, 1, w(4), 1, 1, w(0), 6'b001100, 4, 0);
      add(0, 0, 0,    1, 1, w(1), 6'b000000, 3, 1);
      add(0, 0, 0,    1, 1, w(2), 6'b001100, 2, 1);
      add(0, 0, 0,    1, 1, w(3), 6'b001100, 1, 1);
      add(0, 0, 0,    1, 0, 0,    6'b000000, 0, 1);
      add(0, 1, JR,   0, 0, 0,    6'b000000, 0, 1);
      add(0, 1, JJ,   0, 1, JR,   6'b000001, 1, 1);
      add(0, 1, ORI,  0, 1, JR,   6'b000001, 2, 1);
      add(1, 1, ADI,  1, 0, 0,    6'b000000, 3, 1);
      add(0, 0, 0,    0, 0, 0,    6'b000000, 0, 1);
      add(0, 1, JR,   0, 0, 0,    6'b000000, 0, 1);
      add(0, 1, JJ,   0, 1, JR,   6'b000001, 1, 1);
      add(0, 0, 0,    1, 1, JR,   6'b000001, 2, 1);
      add(0, 0, 0,    1, 1, JJ,   6'b000010, 1, 1);
      add(0, 0, 0,    0, 0, 0,    6'b000000, 0, 1);
      repeat (2) @(posedge clk);
      #1 rst = 0;
`ifndef IFID_BYPASS_EN
      foreach (tv[k]) begin
         cyc(tv[k].fl, tv[k].pv, tv[k].pd, tv[k].pr);
         chk($sformatf("vec%0d_valid", k), 64'(s_valid), 64'(tv[k].ev));
         chk($sformatf("vec%0d_data", k), s_data, tv[k].ed);
         chk($sformatf("vec%0d_flags", k), 64'(s_flags), 64'(tv[k].ef));
         chk($sformatf("vec%0d_count", k), 64'(s_count), 64'(tv[k].ec));
         chk($sformatf("vec%0d_ready", k), 64'(s_pr), 64'(tv[k].epr));
      end
`endif
      // concurrent push and pop holding occupancy at two
      cyc(0, 1, cv(0), 0);
      cyc(0, 1, cv(1), 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, cv(i + 2), 1);
         chk("conc_count", 64'(s_count), 64'd2);
         chk("conc_data", s_data, cv(i));
      end
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      chk("conc_drained", 64'(s_count), 64'd0);
      // asynchronous reset between edges
      cyc(0, 1, w(7), 0);
      cyc(0, 1, w(8), 0);
      cyc(0, 1, w(9), 0);
      flush = 0; push_valid = 1; push_data = w(10); pop_ready = 0;
      #2 rst = 1;
      #1;
      chk("rst_pop_valid", 64'(pop_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      chk("rst_pop_data", pop_data, 64'd0);
      chk("rst_push_ready", 64'(push_ready), 64'd1);
      q.delete();
      @(posedge clk);
      #1 rst = 0;
      cyc(0, 1, LW, 0);
      cyc(0, 0, 0, 0);
      chk("post_rst_count", 64'(s_count), 64'd1);
      chk("post_rst_data", s_data, LW);
      cyc(0, 0, 0, 1);
`ifdef IFID_BYPASS_EN
      cyc(0, 1, ORI, 1);
      chk("byp_valid", 64'(s_valid), 64'd1);
      chk("byp_data", s_data, ORI);
      chk("byp_flags", 64'(s_flags), 64'b010000);
      cyc(0, 0, 0, 0);
      chk("byp_count", 64'(s_count), 64'd0);
`endif
      for (int i = 0; i < 400; i++) begin
         int ops[12] = '{'h00, 'h02, 'h03, 'h08, 'h0D, 'h23, 'h2B, 'h04, 'h0F, 'h20, 'h3F, 'h1A};
         logic [31:0] r;
         logic [31:0] ins;
         r = $urandom;
         ins = {6'(ops[$urandom_range(0, 11)]), r[25:6], 6'($urandom_range(0, 10))};
         cyc($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, {$urandom, ins}, $urandom_range(0, 2) != 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
